// File: rtl/scr1_ialu_arb_pkg.sv
// Shared types for the IALU MUL/DIV request arbiter.
// FSM encoding and default watchdog length.
package scr1_ialu_arb_pkg;

  typedef enum logic [1:0] {
    SCR1_ARB_IDLE,
    SCR1_ARB_BUSY,
    SCR1_ARB_RESP
  } type_scr1_ialu_arb_state_e;

  localparam int unsigned SCR1_IALU_ARB_TMO_CYC = 64;

endpackage

// File: rtl/scr1_rr_arb.sv
// Combinational round-robin pick.
// Search starts at last_i+1 and wraps.
module scr1_rr_arb #(
  parameter int unsigned NREQ = 2
) (
  input  logic [NREQ-1:0]         req_i,
  input  logic [$clog2(NREQ)-1:0] last_i,
  output logic [NREQ-1:0]         gnt_o,
  output logic [$clog2(NREQ)-1:0] idx_o,
  output logic                    vld_o
);

  localparam int unsigned IW = $clog2(NREQ);

  logic          found;
  logic [IW-1:0] pick;
  logic [IW-1:0] cidx;
  int unsigned   c;

  always_comb begin
    found = 1'b0;
    pick  = '0;
    cidx  = '0;
    c     = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      c    = (32'(last_i) + k) % NREQ;
      cidx = IW'(c);
      if (!found && req_i[cidx]) begin
        found = 1'b1;
        pick  = cidx;
      end
    end
  end

  assign vld_o = found;
  assign idx_o = pick;
  assign gnt_o = found ? (NREQ'(1) << pick)
                       : '0;

endmodule

// File: rtl/scr1_ialu_rvm_arb.sv
// Arbiter/sequencer for the shared MUL/DIV path.
// One op in flight; watchdog aborts a stuck op.
module scr1_ialu_rvm_arb
  import scr1_ialu_arb_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned CMD_W   = 5,
  parameter int unsigned NREQ    = 2,
  parameter int unsigned TMO_CYC =
    SCR1_IALU_ARB_TMO_CYC
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_vd_i,
  input  logic [NREQ*CMD_W-1:0] req_cmd_i,
  input  logic [NREQ*XLEN-1:0]  req_op1_i,
  input  logic [NREQ*XLEN-1:0]  req_op2_i,
  output logic [NREQ-1:0]       req_ack_o,
  output logic [NREQ-1:0]       res_vd_o,
  output logic [XLEN-1:0]       res_o,
  output logic                  res_err_o,
  input  logic [NREQ-1:0]       res_ack_i,
  output logic                  arb2ialu_cmd_vd_o,
  output logic [CMD_W-1:0]      arb2ialu_cmd_o,
  output logic [XLEN-1:0]       arb2ialu_op1_o,
  output logic [XLEN-1:0]       arb2ialu_op2_o,
  input  logic                  ialu2arb_res_rdy_i,
  input  logic [XLEN-1:0]       ialu2arb_res_i,
  output logic                  busy_o
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned TW = $clog2(TMO_CYC+1);

  type_scr1_ialu_arb_state_e state_q, state_d;

  logic [IW-1:0]    last_q, last_d;
  logic [IW-1:0]    g_q, g_d;
  logic [CMD_W-1:0] cmd_q, cmd_d;
  logic [XLEN-1:0]  op1_q, op1_d;
  logic [XLEN-1:0]  op2_q, op2_d;
  logic [XLEN-1:0]  res_q, res_d;
  logic             err_q, err_d;
  logic [TW-1:0]    tmr_q, tmr_d;

  logic [NREQ-1:0]  gnt;
  logic [IW-1:0]    gidx;
  logic             gvld;

  scr1_rr_arb #(
    .NREQ (NREQ)
  ) i_rr (
    .req_i  (req_vd_i),
    .last_i (last_q),
    .gnt_o  (gnt),
    .idx_o  (gidx),
    .vld_o  (gvld)
  );

  always_comb begin
    state_d           = state_q;
    last_d            = last_q;
    g_d               = g_q;
    cmd_d             = cmd_q;
    op1_d             = op1_q;
    op2_d             = op2_q;
    res_d             = res_q;
    err_d             = err_q;
    tmr_d             = tmr_q;
    req_ack_o         = '0;
    res_vd_o          = '0;
    arb2ialu_cmd_vd_o = 1'b0;
    unique case (state_q)
      SCR1_ARB_IDLE: begin
        if (gvld) begin
          req_ack_o = gnt;
          g_d       = gidx;
          cmd_d     = req_cmd_i[gidx*CMD_W +: CMD_W];
          op1_d     = req_op1_i[gidx*XLEN +: XLEN];
          op2_d     = req_op2_i[gidx*XLEN +: XLEN];
          tmr_d     = '0;
          state_d   = SCR1_ARB_BUSY;
        end
      end
      SCR1_ARB_BUSY: begin
        arb2ialu_cmd_vd_o = 1'b1;
        // rdy takes priority over the watchdog
        if (ialu2arb_res_rdy_i) begin
          res_d   = ialu2arb_res_i;
          err_d   = 1'b0;
          state_d = SCR1_ARB_RESP;
        end else if (tmr_q == TW'(TMO_CYC-1)) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = SCR1_ARB_RESP;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      SCR1_ARB_RESP: begin
        res_vd_o = NREQ'(1) << g_q;
        if (res_ack_i[g_q]) begin
          last_d  = g_q;
          tmr_d   = '0;
          state_d = SCR1_ARB_IDLE;
        end
      end
      default: state_d = SCR1_ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SCR1_ARB_IDLE;
      last_q  <= IW'(NREQ-1);
      g_q     <= '0;
      cmd_q   <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      g_q     <= g_d;
      cmd_q   <= cmd_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      res_q   <= res_d;
      err_q   <= err_d;
      tmr_q   <= tmr_d;
    end
  end

  assign busy_o    = (state_q != SCR1_ARB_IDLE);
  assign res_o     = (state_q == SCR1_ARB_RESP)
                   ? res_q : '0;
  assign res_err_o = (state_q == SCR1_ARB_RESP)
                   & err_q;

  assign arb2ialu_cmd_o = cmd_q;
  assign arb2ialu_op1_o = op1_q;
  assign arb2ialu_op2_o = op2_q;

endmodule

// File: tb/tb_scr1_ialu_rvm_arb.sv
// Bench for scr1_ialu_rvm_arb: directed cases plus
// random transactions against a round-robin/IALU model.
module tb_scr1_ialu_rvm_arb;

  localparam int XLEN  = 32;
  localparam int CMD_W = 5;
  localparam int NREQ  = 2;
  localparam int TMO   = 8;

  localparam logic [CMD_W-1:0] C_MUL = 5'd1;
  localparam logic [CMD_W-1:0] C_DIV = 5'd2;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NREQ-1:0]       req_vd_i = '0;
  logic [NREQ*CMD_W-1:0] req_cmd_i = '0;
  logic [NREQ*XLEN-1:0]  req_op1_i = '0;
  logic [NREQ*XLEN-1:0]  req_op2_i = '0;
  logic [NREQ-1:0]       req_ack_o;
  logic [NREQ-1:0]       res_vd_o;
  logic [XLEN-1:0]       res_o;
  logic                  res_err_o;
  logic [NREQ-1:0]       res_ack_i = '0;
  logic                  cmd_vd;
  logic [CMD_W-1:0]      cmd_o;
  logic [XLEN-1:0]       op1_o;
  logic [XLEN-1:0]       op2_o;
  logic                  rdy = 1'b0;
  logic [XLEN-1:0]       ires = '0;
  logic                  busy_o;

  int checks = 0;
  int errs   = 0;
  int ptr    = NREQ-1;

  logic [CMD_W-1:0] cmd_a [NREQ];
  logic [XLEN-1:0]  op1_a [NREQ];
  logic [XLEN-1:0]  op2_a [NREQ];

  scr1_ialu_rvm_arb #(
    .XLEN    (XLEN),
    .CMD_W   (CMD_W),
    .NREQ    (NREQ),
    .TMO_CYC (TMO)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .req_vd_i           (req_vd_i),
    .req_cmd_i          (req_cmd_i),
    .req_op1_i          (req_op1_i),
    .req_op2_i          (req_op2_i),
    .req_ack_o          (req_ack_o),
    .res_vd_o           (res_vd_o),
    .res_o              (res_o),
    .res_err_o          (res_err_o),
    .res_ack_i          (res_ack_i),
    .arb2ialu_cmd_vd_o  (cmd_vd),
    .arb2ialu_cmd_o     (cmd_o),
    .arb2ialu_op1_o     (op1_o),
    .arb2ialu_op2_o     (op2_o),
    .ialu2arb_res_rdy_i (rdy),
    .ialu2arb_res_i     (ires),
    .busy_o             (busy_o)
  );

  always #5 clk = ~clk;

  function automatic logic [XLEN-1:0] ref_f(
    input logic [CMD_W-1:0] c,
    input logic [XLEN-1:0]  a,
    input logic [XLEN-1:0]  b
  );
    if (c == C_MUL) return a * b;
    if (b == '0) return '1;
    return a / b;
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s obs=%0h exp=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic drive_req(input logic [NREQ-1:0] m);
    for (int i = 0; i < NREQ; i++) begin
      req_vd_i[i] = m[i];
      req_cmd_i[i*CMD_W +: CMD_W] = cmd_a[i];
      req_op1_i[i*XLEN +: XLEN]   = op1_a[i];
      req_op2_i[i*XLEN +: XLEN]   = op2_a[i];
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    req_vd_i = '0;
    rdy = 1'b0;
    res_ack_i = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    ptr = NREQ-1;
  endtask

  task automatic chk_idle0(input string tag);
    chk({tag, "_busy"}, 64'(busy_o), 0);
    chk({tag, "_resvd"}, 64'(res_vd_o), 0);
    chk({tag, "_ack"}, 64'(req_ack_o), 0);
    chk({tag, "_cvd"}, 64'(cmd_vd), 0);
    chk({tag, "_res"}, 64'(res_o), 0);
    chk({tag, "_err"}, 64'(res_err_o), 0);
  endtask

  task automatic txn(input logic [NREQ-1:0] mask,
                     input int lat,
                     input int hold);
    int w;
    int c;
    logic [XLEN-1:0] er;
    logic ee;
    logic [NREQ-1:0] oh;
    @(posedge clk); #1;
    rdy = 1'b0;
    res_ack_i = '0;
    drive_req(mask);
    w = -1;
    for (int k = 1; k <= NREQ; k++) begin
      c = (ptr + k) % NREQ;
      if (w < 0 && mask[c]) w = c;
    end
    #1;
    if (w < 0) begin
      chk("noreq_ack", 64'(req_ack_o), 0);
      @(posedge clk); #1;
      chk("noreq_busy", 64'(busy_o), 0);
      return;
    end
    oh = NREQ'(1) << w;
    chk("acc_ack", 64'(req_ack_o), 64'(oh));
    chk("acc_busy", 64'(busy_o), 0);
    chk("acc_cvd", 64'(cmd_vd), 0);
    ee = (lat > TMO);
    er = ee ? '0
            : ref_f(cmd_a[w], op1_a[w], op2_a[w]);
    for (int k = 1; k <= TMO; k++) begin
      @(posedge clk); #1;
      rdy  = (k == lat);
      ires = (k == lat)
           ? ref_f(cmd_o, op1_o, op2_o)
           : $urandom;
      #1;
      chk("bz_cvd", 64'(cmd_vd), 1);
      chk("bz_cmd", 64'(cmd_o), 64'(cmd_a[w]));
      chk("bz_op1", 64'(op1_o), 64'(op1_a[w]));
      chk("bz_op2", 64'(op2_o), 64'(op2_a[w]));
      chk("bz_ack", 64'(req_ack_o), 0);
      chk("bz_resvd", 64'(res_vd_o), 0);
      chk("bz_busy", 64'(busy_o), 1);
      if (k == lat) break;
    end
    for (int h = 0; h <= hold; h++) begin
      @(posedge clk); #1;
      rdy  = 1'($urandom_range(0, 1));
      ires = $urandom;
      res_ack_i = (h == hold) ? oh
                : (NREQ'($urandom) & ~oh);
      #1;
      chk("rs_vd", 64'(res_vd_o), 64'(oh));
      chk("rs_res", 64'(res_o), 64'(er));
      chk("rs_err", 64'(res_err_o), 64'(ee));
      chk("rs_cvd", 64'(cmd_vd), 0);
      chk("rs_ack", 64'(req_ack_o), 0);
      chk("rs_busy", 64'(busy_o), 1);
    end
    ptr = w;
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      cmd_a[i] = '0;
      op1_a[i] = '0;
      op2_a[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk_idle0("rst");
    rst = 1'b0;

    cmd_a[0] = C_MUL; op1_a[0] = 7; op2_a[0] = 6;
    txn(2'b01, 3, 0);

    do_reset();
    cmd_a[0] = C_MUL; op1_a[0] = 3;   op2_a[0] = 5;
    cmd_a[1] = C_DIV; op1_a[1] = 100; op2_a[1] = 7;
    repeat (4) txn(2'b11, 1, 0);

    txn(2'b01, 100, 0);
    txn(2'b01, 2, 0);
    txn(2'b01, TMO, 0);
    txn(2'b11, 2, 5);
    txn(2'b00, 1, 0);

    @(posedge clk); #1;
    rdy = 1'b0;
    res_ack_i = '0;
    drive_req(2'b01);
    @(posedge clk); #1;
    drive_req(2'b00);
    #1;
    chk("mid_cvd", 64'(cmd_vd), 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    rdy = 1'b1;
    ires = 32'hdead_beef;
    #1;
    chk_idle0("midrst");
    chk("midrst_cmd", 64'(cmd_o), 0);
    chk("midrst_op1", 64'(op1_o), 0);
    @(posedge clk); #1;
    rdy = 1'b0;
    chk("late_busy", 64'(busy_o), 0);
    chk("late_resvd", 64'(res_vd_o), 0);
    ptr = NREQ-1;
    txn(2'b11, 1, 0);

    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        cmd_a[i] = $urandom_range(0, 1) ? C_MUL
                                        : C_DIV;
        op1_a[i] = $urandom;
        op2_a[i] = $urandom_range(0, 3) == 0
                 ? XLEN'($urandom_range(0, 9))
                 : $urandom;
      end
      txn(NREQ'($urandom),
          $urandom_range(1, TMO+2),
          $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end

endmodule
